// File: rtl/peripheral_arbiter_spram_axi4.sv
// Round-robin arbiter sharing one single-port RAM slave port among NM masters.
// The grant is held for the owner's whole cycle (cyc high), bursts included.
// Every ownership ends with one idle bubble so the RAM sees cyc/stb low
// before the next owner starts.
module peripheral_arbiter_spram_axi4 #(
  parameter int NM = 2,
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic               axi4_clk_i,
  input  logic               axi4_rst_i,
  input  logic [NM*AW-1:0]   axi4_m_adr_i,
  input  logic [NM*DW-1:0]   axi4_m_dat_i,
  input  logic [NM*DW/8-1:0] axi4_m_sel_i,
  input  logic [NM-1:0]      axi4_m_we_i,
  input  logic [NM*2-1:0]    axi4_m_bte_i,
  input  logic [NM*3-1:0]    axi4_m_cti_i,
  input  logic [NM-1:0]      axi4_m_cyc_i,
  input  logic [NM-1:0]      axi4_m_stb_i,
  output logic [NM-1:0]      axi4_m_ack_o,
  output logic [NM-1:0]      axi4_m_err_o,
  output logic [DW-1:0]      axi4_m_dat_o,
  output logic [AW-1:0]      axi4_s_adr_o,
  output logic [DW-1:0]      axi4_s_dat_o,
  output logic [DW/8-1:0]    axi4_s_sel_o,
  output logic               axi4_s_we_o,
  output logic [1:0]         axi4_s_bte_o,
  output logic [2:0]         axi4_s_cti_o,
  output logic               axi4_s_cyc_o,
  output logic               axi4_s_stb_o,
  input  logic               axi4_s_ack_i,
  input  logic               axi4_s_err_i,
  input  logic [DW-1:0]      axi4_s_dat_i,
  output logic [NM-1:0]      gnt_o
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] next_idx;
  logic [IW-1:0] cand;
  logic [NM-1:0] gnt_oh;

  // Round-robin search: first requester after last_idx, wrapping modulo NM.
  // Scanning from the farthest offset down lets the nearest requester win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_idx = last_idx;
    cand     = '0;
    for (int k = NM; k >= 1; k--) begin
      cand = IW'((int'(last_idx) + k) % NM);
      if (axi4_m_cyc_i[cand]) next_idx = cand;
    end
  end

  // Grant FSM: IDLE picks the next owner, BUSY holds it until its cyc drops.
  always_ff @(posedge axi4_clk_i) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (axi4_rst_i) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_idx <= IW'(NM - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|axi4_m_cyc_i) begin
            state    <= BUSY;
            gnt_idx  <= next_idx;
            last_idx <= next_idx;
          end
        end
        default: begin
          if (!axi4_m_cyc_i[gnt_idx]) state <= IDLE;
        end
      endcase
    end
  end

  // One-hot view of the current grant; all zero while IDLE.
  always_comb begin
    gnt_oh = '0;
    if (state == BUSY) gnt_oh[gnt_idx] = 1'b1;
  end

  // Route the owner's request fields to the slave; everything is 0 when idle.
  always_comb begin
    axi4_s_adr_o = '0;
    axi4_s_dat_o = '0;
    axi4_s_sel_o = '0;
    axi4_s_we_o  = 1'b0;
    axi4_s_bte_o = '0;
    axi4_s_cti_o = '0;
    axi4_s_cyc_o = 1'b0;
    axi4_s_stb_o = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_oh[i]) begin
        axi4_s_adr_o = axi4_m_adr_i[i*AW +: AW];
        axi4_s_dat_o = axi4_m_dat_i[i*DW +: DW];
        axi4_s_sel_o = axi4_m_sel_i[i*SW +: SW];
        axi4_s_we_o  = axi4_m_we_i[i];
        axi4_s_bte_o = axi4_m_bte_i[i*2 +: 2];
        axi4_s_cti_o = axi4_m_cti_i[i*3 +: 3];
        axi4_s_cyc_o = axi4_m_cyc_i[i];
        axi4_s_stb_o = axi4_m_stb_i[i];
      end
    end
  end

  // Responses go only to the owner; read data is broadcast unqualified.
  assign axi4_m_ack_o = gnt_oh & {NM{axi4_s_ack_i}};
  assign axi4_m_err_o = gnt_oh & {NM{axi4_s_err_i}};
  assign axi4_m_dat_o = axi4_s_dat_i;
  assign gnt_o        = gnt_oh;

endmodule

// File: tb/tb_peripheral_arbiter_spram_axi4.sv
// Bench for the round-robin RAM arbiter: a 2-master instance in front of a
// small behavioural RAM, plus a 3-master instance for rotation and err routing.
module tb_peripheral_arbiter_spram_axi4;

  localparam int NM = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Master side of the 2-master instance
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_wdat;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [NM*2-1:0]  m_bte;
  logic [NM*3-1:0]  m_cti;
  logic [NM-1:0]    m_ack, m_err, gnt;
  logic [DW-1:0]    m_rdat;

  // Slave side
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [3:0]    s_sel;
  logic          s_we, s_cyc, s_stb;
  logic [1:0]    s_bte;
  logic [2:0]    s_cti;
  logic          s_ack = 1'b0;
  logic          s_err;
  logic [DW-1:0] s_rdat = '0;

  peripheral_arbiter_spram_axi4 #(.NM(NM), .AW(AW), .DW(DW)) u_dut (
    .axi4_clk_i(clk), .axi4_rst_i(rst),
    .axi4_m_adr_i(m_adr), .axi4_m_dat_i(m_wdat), .axi4_m_sel_i(m_sel),
    .axi4_m_we_i(m_we), .axi4_m_bte_i(m_bte), .axi4_m_cti_i(m_cti),
    .axi4_m_cyc_i(m_cyc), .axi4_m_stb_i(m_stb),
    .axi4_m_ack_o(m_ack), .axi4_m_err_o(m_err), .axi4_m_dat_o(m_rdat),
    .axi4_s_adr_o(s_adr), .axi4_s_dat_o(s_wdat), .axi4_s_sel_o(s_sel),
    .axi4_s_we_o(s_we), .axi4_s_bte_o(s_bte), .axi4_s_cti_o(s_cti),
    .axi4_s_cyc_o(s_cyc), .axi4_s_stb_o(s_stb),
    .axi4_s_ack_i(s_ack), .axi4_s_err_i(s_err), .axi4_s_dat_i(s_rdat),
    .gnt_o(gnt)
  );

  // 3-master instance: slave never acks, err tied high
  logic [3*AW-1:0] m3_adr = '0;
  logic [3*DW-1:0] m3_wdat = '0;
  logic [3*4-1:0]  m3_sel = '0;
  logic [2:0]      m3_we = '0, m3_stb = '0, m3_cyc;
  logic [3*2-1:0]  m3_bte = '0;
  logic [3*3-1:0]  m3_cti = '0;
  logic [2:0]      m3_ack, m3_err, gnt3;
  logic [DW-1:0]   m3_rdat;
  logic [AW-1:0]   s3_adr;
  logic [DW-1:0]   s3_wdat;
  logic [3:0]      s3_sel;
  logic            s3_we, s3_cyc, s3_stb;
  logic [1:0]      s3_bte;
  logic [2:0]      s3_cti;

  peripheral_arbiter_spram_axi4 #(.NM(3), .AW(AW), .DW(DW)) u_dut3 (
    .axi4_clk_i(clk), .axi4_rst_i(rst),
    .axi4_m_adr_i(m3_adr), .axi4_m_dat_i(m3_wdat), .axi4_m_sel_i(m3_sel),
    .axi4_m_we_i(m3_we), .axi4_m_bte_i(m3_bte), .axi4_m_cti_i(m3_cti),
    .axi4_m_cyc_i(m3_cyc), .axi4_m_stb_i(m3_stb),
    .axi4_m_ack_o(m3_ack), .axi4_m_err_o(m3_err), .axi4_m_dat_o(m3_rdat),
    .axi4_s_adr_o(s3_adr), .axi4_s_dat_o(s3_wdat), .axi4_s_sel_o(s3_sel),
    .axi4_s_we_o(s3_we), .axi4_s_bte_o(s3_bte), .axi4_s_cti_o(s3_cti),
    .axi4_s_cyc_o(s3_cyc), .axi4_s_stb_o(s3_stb),
    .axi4_s_ack_i(1'b0), .axi4_s_err_i(1'b1), .axi4_s_dat_i(32'h0),
    .gnt_o(gnt3)
  );

  // Behavioural RAM: one ack per strobe, never two in a row.
  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (s_cyc && s_stb && !s_ack) begin
      s_ack  <= 1'b1;
      s_rdat <= mem[s_adr[7:2]];
      if (s_we)
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_wdat[8*b +: 8];
    end else begin
      s_ack <= 1'b0;
    end
  end

  int tests = 0;
  int failed = 0;
  int stray = 0;
  logic [31:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int          m;
    bit          we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  // Single classic access by one master, then release and check the bubble.
  task automatic xfer(input vec_t v);
    bit got;
    logic [31:0] e;
    m_adr[v.m*AW +: AW] = v.adr;
    m_wdat[v.m*DW +: DW] = v.dat;
    m_sel[v.m*4 +: 4] = v.sel;
    m_cti[v.m*3 +: 3] = 3'b000;
    m_we[v.m] = v.we;
    m_cyc[v.m] = 1'b1;
    m_stb[v.m] = 1'b1;
    if (!v.we) sb.push_back(v.exp);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if ((m_ack & ~(NM'(1) << v.m)) != '0) stray++;
      if (m_ack[v.m]) got = 1'b1;
    end
    check("vec_ack", 32'(got), 32'd1);
    if (got) begin
      check("vec_s_adr", 32'(s_adr), 32'(v.adr));
      check("vec_gnt", 32'(gnt), 32'(1) << v.m);
      if (!v.we && sb.size() > 0) begin
        e = sb.pop_front();
        check("vec_rdata", m_rdat, e);
      end
    end
    m_cyc[v.m] = 1'b0;
    m_stb[v.m] = 1'b0;
    m_we[v.m] = 1'b0;
    tick();
    check("vec_release", 32'(gnt), 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    bit got;
    int exp_m;
    logic [31:0] e;

    vecs[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{0, 1'b0, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 8'h14, 32'h12345678, 4'h3, 32'h0};
    vecs[3] = '{1, 1'b0, 8'h14, 32'h0,        4'hF, 32'h00005678};
    vecs[4] = '{0, 1'b1, 8'h14, 32'hAABBCCDD, 4'hC, 32'h0};
    vecs[5] = '{1, 1'b0, 8'h14, 32'h0,        4'hF, 32'hAABB5678};
    vecs[6] = '{1, 1'b0, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF};

    m_adr = '0; m_wdat = '0; m_sel = '0; m_we = '0;
    m_cyc = '0; m_stb = '0; m_bte = '0; m_cti = '0;
    s_err = 1'b0; m3_cyc = '0;

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_s_cyc", 32'(s_cyc), 32'd0);
    check("rst_ack", 32'(m_ack), 32'd0);
    check("rst_gnt3", 32'(gnt3), 32'd0);

    // Simultaneous request after reset: m0 first, bubble, then m1
    m_cyc = 2'b11;
    tick();
    check("sim_gnt0", 32'(gnt), 32'd1);
    tick();
    check("sim_hold", 32'(gnt), 32'd1);
    m_cyc[0] = 1'b0;
    tick();
    check("sim_bubble", 32'(gnt), 32'd0);
    tick();
    check("sim_gnt1", 32'(gnt), 32'd2);
    m_cyc = '0;
    tick();

    // Table of classic accesses
    for (int i = 0; i < 7; i++) xfer(vecs[i]);

    // Both masters continuously requesting: 0,1,0,1 with bubbles
    do_reset();
    m_adr = {8'h34, 8'h30};
    m_we = '0;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    exp_m = 0;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        if (m_ack[exp_m]) got = 1'b1;
      end
      check("rr_ack", 32'(got), 32'd1);
      check("rr_gnt", 32'(gnt), 32'(1) << exp_m);
      m_cyc[exp_m] = 1'b0;
      m_stb[exp_m] = 1'b0;
      tick();
      check("rr_bubble", 32'(gnt), 32'd0);
      m_cyc[exp_m] = 1'b1;
      m_stb[exp_m] = 1'b1;
      exp_m = 1 - exp_m;
    end
    m_cyc = '0;
    m_stb = '0;
    tick();
    tick();

    // m1 4-beat incrementing burst while m0 waits
    m_we = 2'b10;
    m_sel = 8'hFF;
    m_bte = '0;
    m_adr[AW +: AW] = 8'h20;
    m_cti[3 +: 3] = 3'b010;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    tick();
    check("bst_gnt_start", 32'(gnt), 32'd2);
    m_adr[0 +: AW] = 8'h40;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_adr[AW +: AW] = 8'(8'h20 + 4 * k);
      m_wdat[DW +: DW] = 32'h100 + 32'(k);
      m_cti[3 +: 3] = (k == 3) ? 3'b111 : 3'b010;
      sb.push_back(32'h20 + 32'(4 * k));
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        if (m_ack[0]) stray++;
        if (m_ack[1]) got = 1'b1;
      end
      check("bst_ack", 32'(got), 32'd1);
      e = sb.pop_front();
      if (got) begin
        check("bst_adr", 32'(s_adr), e);
        check("bst_gnt", 32'(gnt), 32'd2);
      end
    end
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    m_we = '0;
    tick();
    check("bst_bubble", 32'(gnt), 32'd0);
    tick();
    check("bst_m0_gnt", 32'(gnt), 32'd1);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (m_ack[0]) got = 1'b1;
    end
    check("bst_m0_ack", 32'(got), 32'd1);
    check("bst_m0_rd", m_rdat, 32'h0);
    m_cyc = '0;
    m_stb = '0;
    tick();

    // Reset during beat 2 of an m0 burst
    m_adr[0 +: AW] = 8'h50;
    m_cti[0 +: 3] = 3'b010;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (m_ack[0]) got = 1'b1;
    end
    check("mrst_beat1", 32'(got), 32'd1);
    m_adr[0 +: AW] = 8'h54;
    m_cyc[1] = 1'b1;
    rst = 1'b1;
    tick();
    check("mrst_s_cyc", 32'(s_cyc), 32'd0);
    check("mrst_gnt", 32'(gnt), 32'd0);
    check("mrst_ack", 32'(m_ack), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst_regrant", 32'(gnt), 32'd1);
    m_cyc = '0;
    m_stb = '0;
    m_cti = '0;
    tick();
    tick();

    // NM=3 rotation and err routing
    m3_cyc = 3'b111;
    exp_m = 0;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick();
        if (gnt3 != '0) got = 1'b1;
      end
      check("nm3_gnt", 32'(gnt3), 32'(1) << exp_m);
      check("nm3_err", 32'(m3_err), 32'(1) << exp_m);
      m3_cyc[exp_m] = 1'b0;
      tick();
      check("nm3_bubble", 32'(gnt3), 32'd0);
      check("nm3_err_idle", 32'(m3_err), 32'd0);
      m3_cyc[exp_m] = 1'b1;
      exp_m = (exp_m + 1) % 3;
    end
    m3_cyc = '0;
    tick();

    check("no_stray_ack", 32'(stray), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
